// File: rtl/conv_mac_seq_if.sv
// conv_mac_seq_if: control, operand stream and result handshake bundle for conv_mac_seq
interface conv_mac_seq_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W = 24,
  parameter int OUT_W = 16,
  parameter int IN_CH = 2,
  parameter int KSIZE = 3
);
  localparam int N = IN_CH * KSIZE * KSIZE;
  localparam int CNT_W = N > 1 ? $clog2(N) : 1;
  localparam int CH_W = IN_CH > 1 ? $clog2(IN_CH) : 1;
  logic start;
  logic signed [ACC_W-1:0] bias;
  logic busy;
  logic din_valid;
  logic din_ready;
  logic signed [DATA_W-1:0] din;
  logic signed [DATA_W-1:0] wgt;
  logic [CNT_W-1:0] cnt;
  logic [CH_W-1:0] ch;
  logic res_valid;
  logic res_ready;
  logic signed [OUT_W-1:0] res;
  logic sat;
  logic done;
  modport master (
    output start, bias, din_valid, din, wgt, res_ready,
    input busy, din_ready, cnt, ch, res_valid, res, sat, done
  );
  modport slave (
    input start, bias, din_valid, din, wgt, res_ready,
    output busy, din_ready, cnt, ch, res_valid, res, sat, done
  );
endinterface

// File: rtl/conv_mac_seq.sv
// conv_mac_seq: streamed multi-channel conv MAC with bias, shift and saturation; define CONV_RELU_EN to rectify
module conv_mac_seq #(
  parameter int DATA_W = 8,
  parameter int ACC_W = 24,
  parameter int OUT_W = 16,
  parameter int IN_CH = 2,
  parameter int KSIZE = 3,
  parameter int SHIFT = 0
) (
  input logic clk,
  input logic rst,
  conv_mac_seq_if.slave bus
);
  localparam int KK = KSIZE * KSIZE;
  localparam int N = IN_CH * KK;
  localparam int CNT_W = N > 1 ? $clog2(N) : 1;
  localparam int CH_W = IN_CH > 1 ? $clog2(IN_CH) : 1;
  localparam int KK_W = KK > 1 ? $clog2(KK) : 1;
  localparam int EW = ACC_W > OUT_W ? ACC_W : OUT_W;
  localparam logic signed [EW-1:0] MAX = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EW-1:0] MIN = {{(EW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, ACC, BIAS, OUT} state_t;
  state_t state, state_n;
  logic beat, last, kwrap, done_q, sat_q, sat_n;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0] acc, bias_q, sum, t, t_r;
  logic signed [EW-1:0] t_e;
  logic signed [OUT_W-1:0] res_q, res_n;
  logic [CNT_W-1:0] cnt;
  logic [CH_W-1:0] ch;
  logic [KK_W-1:0] kcnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = state == IDLE ? (bus.start ? ACC : IDLE) :
              state == ACC  ? (beat && last ? BIAS : ACC) :
              state == BIAS ? OUT :
              (bus.res_ready ? IDLE : OUT);
  always_comb begin
    bus.busy = state != IDLE;
    bus.din_ready = state == ACC;
    bus.res_valid = state == OUT;
  end
  assign beat = bus.din_valid & bus.din_ready;
  assign last = cnt == CNT_W'(N - 1);
  assign kwrap = kcnt == KK_W'(KK - 1);
  always_comb begin
    prod = bus.din * bus.wgt;
    sum = acc + bias_q;
    t = sum >>> SHIFT;
`ifdef CONV_RELU_EN
    t_r = t < 0 ? '0 : t;
`else
    t_r = t;
`endif
    t_e = EW'(t_r);
    sat_n = t_e > MAX || t_e < MIN;
    res_n = t_e > MAX ? OUT_W'(MAX) : t_e < MIN ? OUT_W'(MIN) : OUT_W'(t_e);
  end
  // kcnt tracks the tap within a kernel window so ch avoids a divider
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc <= '0;
      bias_q <= '0;
      cnt <= '0;
      ch <= '0;
      kcnt <= '0;
      res_q <= '0;
      sat_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= state == OUT && bus.res_ready;
      if (state == IDLE && bus.start) begin
        bias_q <= bus.bias;
        acc <= '0;
        cnt <= '0;
        ch <= '0;
        kcnt <= '0;
      end
      if (beat) begin
        acc <= acc + ACC_W'(prod);
        cnt <= last ? '0 : cnt + 1'b1;
        kcnt <= last || kwrap ? '0 : kcnt + 1'b1;
        ch <= last ? '0 : kwrap ? ch + 1'b1 : ch;
      end
      if (state == BIAS) begin
        acc <= sum;
        res_q <= res_n;
        sat_q <= sat_n;
      end
    end
  assign bus.cnt = cnt;
  assign bus.ch = ch;
  assign bus.res = res_q;
  assign bus.sat = sat_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_conv_mac_seq.sv
// tb_conv_mac_seq: randomized self-checking bench; SHIFT=0 and SHIFT=4 instances run in lockstep
module tb_conv_mac_seq;
  localparam int N = 18;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  int d[N];
  int w[N];
  conv_mac_seq_if bus();
  conv_mac_seq_if bus4();
  conv_mac_seq u (.clk(clk), .rst(rst), .bus(bus));
  conv_mac_seq #(.SHIFT(4)) u4 (.clk(clk), .rst(rst), .bus(bus4));
  assign bus4.start = bus.start;
  assign bus4.bias = bus.bias;
  assign bus4.din_valid = bus.din_valid;
  assign bus4.din = bus.din;
  assign bus4.wgt = bus.wgt;
  assign bus4.res_ready = bus.res_ready;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input int b, input int sh, output logic signed [15:0] r, output logic s);
    longint sum;
    logic signed [23:0] a;
    longint t;
    sum = b;
    for (int i = 0; i < N; i++) sum += longint'(d[i]) * longint'(w[i]);
    a = sum[23:0];
    t = longint'(a) >>> sh;
`ifdef CONV_RELU_EN
    if (t < 0) t = 0;
`endif
    s = t > 32767 || t < -32768;
    r = t > 32767 ? 16'sh7fff : t < -32768 ? 16'sh8000 : t[15:0];
  endfunction

  task automatic fill(input int dv, input int wv);
    for (int i = 0; i < N; i++) begin
      d[i] = dv;
      w[i] = wv;
    end
  endtask

  task automatic feed(input int b, input bit gaps, output int cyc);
    bus.start = 1'b1;
    bus.bias = b[23:0];
    tick();
    bus.start = 1'b0;
    cyc = 1;
    for (int i = 0; i < N; i++) begin
      while (gaps && $urandom_range(0, 2) == 0) begin
        bus.din_valid = 1'b0;
        tick();
        cyc++;
      end
      bus.din_valid = 1'b1;
      bus.din = d[i][7:0];
      bus.wgt = w[i][7:0];
      tick();
      cyc++;
    end
    bus.din_valid = 1'b0;
  endtask

  task automatic collect(input int stall, output logic signed [15:0] r, output logic s,
                         output logic signed [15:0] r4, output logic s4, output int cyc, output bit tmo);
    cyc = 0;
    while (!bus.res_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    tmo = !bus.res_valid;
    r = bus.res;
    s = bus.sat;
    r4 = bus4.res;
    s4 = bus4.sat;
    repeat (stall) begin
      tick();
      cyc++;
    end
    bus.res_ready = 1'b1;
    tick();
    cyc++;
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 0; bus.bias = 0; bus.din_valid = 0; bus.din = 0; bus.wgt = 0; bus.res_ready = 0;
    rst = 1'b1;
    repeat (2) tick();
    n_chk++;
    if ({bus.busy, bus.din_ready, bus.cnt, bus.ch, bus.res_valid, bus.res, bus.sat, bus.done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b rdy=%b cnt=%0d ch=%0d rv=%b res=%0d sat=%b done=%b want all 0",
               bus.busy, bus.din_ready, bus.cnt, bus.ch, bus.res_valid, bus.res, bus.sat, bus.done);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_unit_sum();
    fill(1, 1);
    bus.start = 1'b1;
    bus.bias = 0;
    tick();
    bus.start = 1'b0;
    n_chk++;
    if (bus.busy !== 1'b1 || bus.din_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL unit_start: got busy=%b rdy=%b want 1 1", bus.busy, bus.din_ready);
    end
    for (int i = 0; i < N; i++) begin
      bus.din_valid = 1'b1;
      bus.din = 8'sd1;
      bus.wgt = 8'sd1;
      tick();
    end
    bus.din_valid = 1'b0;
    n_chk++;
    if (bus.res_valid !== 1'b0 || bus.din_ready !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL unit_bias_cycle: got rv=%b rdy=%b busy=%b want 0 0 1", bus.res_valid, bus.din_ready, bus.busy);
    end
    tick();
    n_chk++;
    if (bus.res_valid !== 1'b1 || bus.res !== 16'sd18 || bus.sat !== 1'b0) begin
      n_fail++;
      $display("FAIL unit_result: got rv=%b res=%0d sat=%b want 1 18 0", bus.res_valid, bus.res, bus.sat);
    end
    n_chk++;
    if (bus4.res !== 16'sd1 || bus4.sat !== 1'b0) begin
      n_fail++;
      $display("FAIL unit_shift4: got res=%0d sat=%b want 1 0", bus4.res, bus4.sat);
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    n_chk++;
    if (bus.res_valid !== 1'b0 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL unit_handshake: got rv=%b done=%b busy=%b want 0 1 0", bus.res_valid, bus.done, bus.busy);
    end
    tick();
    n_chk++;
    if (bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL unit_done_pulse: got done=%b want 0", bus.done);
    end
  endtask

  task automatic test_backpressure();
    int i;
    int cyc;
    i = 0;
    cyc = 0;
    bus.start = 1'b1;
    bus.bias = 0;
    tick();
    bus.start = 1'b0;
    while (i < N) begin
      bus.din_valid = cyc[0];
      bus.din = 8'sd1;
      bus.wgt = 8'sd1;
      n_chk++;
      if (bus.cnt !== 5'(i) || bus.ch !== 1'(i / 9)) begin
        n_fail++;
        $display("FAIL bp_index: got cnt=%0d ch=%0d want %0d %0d", bus.cnt, bus.ch, i, i / 9);
      end
      tick();
      if (bus.din_valid) i++;
      cyc++;
    end
    bus.din_valid = 1'b0;
    n_chk++;
    if (bus.cnt !== 5'd0 || bus.ch !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_wrap: got cnt=%0d ch=%0d want 0 0", bus.cnt, bus.ch);
    end
    tick();
    n_chk++;
    if (bus.res_valid !== 1'b1 || bus.res !== 16'sd18) begin
      n_fail++;
      $display("FAIL bp_result: got rv=%b res=%0d want 1 18", bus.res_valid, bus.res);
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    tick();
  endtask

  task automatic test_pixel(input string name, input int dv, input int wv, input int b);
    logic signed [15:0] r, r4, er, er4;
    logic s, s4, es, es4;
    int c1, c2;
    bit tmo;
    fill(dv, wv);
    feed(b, 1'b0, c1);
    collect(0, r, s, r4, s4, c2, tmo);
    model(b, 0, er, es);
    model(b, 4, er4, es4);
    n_chk++;
    if (tmo || r !== er || s !== es) begin
      n_fail++;
      $display("FAIL %s: got res=%0d sat=%b tmo=%b want %0d %b", name, r, s, tmo, er, es);
    end
    n_chk++;
    if (r4 !== er4 || s4 !== es4) begin
      n_fail++;
      $display("FAIL %s_shift4: got res=%0d sat=%b want %0d %b", name, r4, s4, er4, es4);
    end
  endtask

  task automatic test_fixed_values();
    test_pixel("sat_bias", 127, 127, 100);
    n_chk++;
    if (bus.res !== 16'sd32767 || bus.sat !== 1'b1 || bus4.res !== 16'sd18151 || bus4.sat !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_literal: got res=%0d sat=%b res4=%0d sat4=%b want 32767 1 18151 0",
               bus.res, bus.sat, bus4.res, bus4.sat);
    end
    test_pixel("sign_path", -1, 1, -2);
`ifdef CONV_RELU_EN
    n_chk++;
    if (bus.res !== 16'sd0 || bus.sat !== 1'b0) begin
      n_fail++;
      $display("FAIL sign_literal: got res=%0d sat=%b want 0 0", bus.res, bus.sat);
    end
`else
    n_chk++;
    if (bus.res !== -16'sd20 || bus.sat !== 1'b0) begin
      n_fail++;
      $display("FAIL sign_literal: got res=%0d sat=%b want -20 0", bus.res, bus.sat);
    end
`endif
  endtask

  task automatic test_out_stall();
    int c;
    fill(1, 1);
    feed(0, 1'b0, c);
    tick();
    for (int k = 0; k < 5; k++) begin
      bus.start = k == 2;
      tick();
      n_chk++;
      if (bus.res_valid !== 1'b1 || bus.res !== 16'sd18 || bus.done !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold: got rv=%b res=%0d done=%b want 1 18 0", bus.res_valid, bus.res, bus.done);
      end
    end
    bus.start = 1'b0;
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    n_chk++;
    if (bus.done !== 1'b1 || bus.res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_done: got done=%b rv=%b want 1 0", bus.done, bus.res_valid);
    end
    tick();
    n_chk++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_start_ignored: got done=%b busy=%b want 0 0", bus.done, bus.busy);
    end
    test_pixel("stall_fresh", 3, -2, 7);
  endtask

  task automatic test_reset_mid();
    logic signed [15:0] r, r4;
    logic s, s4;
    int c1, c2;
    bit tmo;
    fill(1, 1);
    bus.start = 1'b1;
    bus.bias = 24'sd1000;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.din_valid = 1'b1;
      bus.din = 8'sd1;
      bus.wgt = 8'sd1;
      tick();
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if ({bus.busy, bus.din_ready, bus.cnt, bus.ch, bus.res_valid, bus.res, bus.sat, bus.done} !== '0) begin
      n_fail++;
      $display("FAIL midrst_async: got busy=%b rdy=%b cnt=%0d ch=%0d rv=%b res=%0d want all 0",
               bus.busy, bus.din_ready, bus.cnt, bus.ch, bus.res_valid, bus.res);
    end
    bus.din_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    n_chk++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_idle: got busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
    feed(5, 1'b0, c1);
    collect(0, r, s, r4, s4, c2, tmo);
    n_chk++;
    if (tmo || r !== 16'sd23 || s !== 1'b0 || r4 !== 16'sd1) begin
      n_fail++;
      $display("FAIL midrst_pixel: got res=%0d sat=%b res4=%0d tmo=%b want 23 0 1", r, s, r4, tmo);
    end
  endtask

  task automatic test_random();
    logic signed [15:0] r, r4, er, er4;
    logic s, s4, es, es4;
    int b, c1, c2;
    bit tmo;
    for (int it = 0; it < 10; it++) begin
      for (int i = 0; i < N; i++) begin
        d[i] = int'($urandom_range(0, 255)) - 128;
        w[i] = int'($urandom_range(0, 255)) - 128;
      end
      b = it[0] ? int'($urandom_range(0, 16777215)) - 8388608 : int'($urandom_range(0, 40000)) - 20000;
      feed(b, 1'b1, c1);
      collect(int'($urandom_range(0, 3)), r, s, r4, s4, c2, tmo);
      model(b, 0, er, es);
      model(b, 4, er4, es4);
      n_chk++;
      if (tmo || r !== er || s !== es || r4 !== er4 || s4 !== es4) begin
        n_fail++;
        $display("FAIL random_%0d: got res=%0d sat=%b res4=%0d sat4=%b tmo=%b want %0d %b %0d %b",
                 it, r, s, r4, s4, tmo, er, es, er4, es4);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic signed [15:0] r, r4, er, er4;
    logic s, s4, es, es4;
    int c1, c2;
    bit tmo;
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < N; i++) begin
        d[i] = int'($urandom_range(0, 31)) - 16;
        w[i] = int'($urandom_range(0, 31)) - 16;
      end
      feed(it * 11 - 9, 1'b0, c1);
      collect(0, r, s, r4, s4, c2, tmo);
      model(it * 11 - 9, 0, er, es);
      model(it * 11 - 9, 4, er4, es4);
      n_chk++;
      if (c1 + c2 != N + 3 || tmo) begin
        n_fail++;
        $display("FAIL b2b_cycles_%0d: got %0d cycles want %0d", it, c1 + c2, N + 3);
      end
      n_chk++;
      if (r !== er || s !== es || r4 !== er4 || s4 !== es4) begin
        n_fail++;
        $display("FAIL b2b_result_%0d: got res=%0d sat=%b res4=%0d want %0d %b %0d", it, r, s, r4, er, es, er4);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_unit_sum();
    test_backpressure();
    test_fixed_values();
    test_out_stall();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
